// File: rtl/forwarding_unit.sv
// Operand-forwarding select generator and load-use stall/bubble control for a 5-stage pipeline.
// Forward codes and bubble flag are registered at the ID->EX edge; stall_id is combinational.
module forwarding_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  flush,
   output logic [1:0]            forward_rs1,
   output logic [1:0]            forward_rs2,
   output logic                  stall_id,
   output logic                  bubble_ex,
   output logic [CNT_W-1:0]      stall_count
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } stage_t;

   localparam stage_t STAGE_NONE = '0;

   // A WB-stage result reaches EX through the write-first register file, so
   // only the EX and MEM destination records are needed to pick a select code.
   stage_t ex_q;
   stage_t mem_q;
   stage_t id_rec;
   logic   bubble;
   logic   rs1_hazard;
   logic   rs2_hazard;

   function automatic logic produces(input stage_t s, input logic [REG_ADDR_W-1:0] r);
      return s.valid && s.reg_write && (s.rd == r) && (r != '0);
   endfunction

   function automatic logic [1:0] fwd_code(input stage_t ex_s, input stage_t mem_s,
                                           input logic [REG_ADDR_W-1:0] rs, input logic used);
      logic [1:0] code;
      code = 2'b00;
      if (used) begin
         if (produces(ex_s, rs) && !ex_s.mem_read)
            code = 2'b01;
         else if (produces(mem_s, rs))
            code = 2'b10;
      end
      return code;
   endfunction

   always_comb begin
      id_rec.valid     = id_valid;
      id_rec.rd        = id_rd;
      id_rec.reg_write = id_reg_write;
      id_rec.mem_read  = id_mem_read;
      rs1_hazard = id_rs1_used && produces(ex_q, id_rs1);
      rs2_hazard = id_rs2_used && produces(ex_q, id_rs2);
      // flush wins: the dependent in ID is being killed, so holding it is pointless
      stall_id   = id_valid && !flush && ex_q.mem_read && (rs1_hazard || rs2_hazard);
      bubble     = stall_id || flush || !id_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= STAGE_NONE;
         mem_q       <= STAGE_NONE;
         forward_rs1 <= 2'b00;
         forward_rs2 <= 2'b00;
         bubble_ex   <= 1'b1;
         stall_count <= '0;
      end else begin
         mem_q     <= flush ? STAGE_NONE : ex_q;
         bubble_ex <= bubble;
         if (bubble) begin
            ex_q        <= STAGE_NONE;
            forward_rs1 <= 2'b00;
            forward_rs2 <= 2'b00;
         end else begin
            ex_q        <= id_rec;
            forward_rs1 <= fwd_code(ex_q, mem_q, id_rs1, id_rs1_used);
            forward_rs2 <= fwd_code(ex_q, mem_q, id_rs2, id_rs2_used);
         end
         if (stall_id && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule
